car_call_panel: RTL and testbench

Parametrised in-car floor-select panel. Converts raw one-hot floor buttons into a stream of floor requests for the car request queue. Synchronises and debounces each button and latches presses as pending calls, which also drive the button lights. Presents one request at a time over a valid/ready handshake and clears a call when the car reports arrival at that floor.

---
 rtl/car_panel_pkg.sv | 25 ++
 rtl/button_debouncer.sv | 71 +++++++
 rtl/car_call_panel.sv | 117 +++++++++++
 tb/tb_car_call_panel.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/car_panel_pkg.sv
// Shared types and helpers for the in-car floor-select panel.
// Floor count is limited to MAX_FLOORS by the width of lowest_set().
package car_panel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam int MAX_FLOORS = 64;
  localparam int IDX_W      = 6;

  // Scans from the top so the last hit, and thus the result, is the lowest set bit.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [MAX_FLOORS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, optional hold counter, rising-edge press pulse.
// The counter exists only when CAR_PANEL_DEBOUNCE_EN is defined.
module button_debouncer
  import car_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic meta_q;
  logic sync_q;
  logic deb_prev_q;
  logic deb_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= button;
      sync_q <= meta_q;
    end
  end

`ifdef CAR_PANEL_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!sync_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A low sample drops the level at once; the count only gates the rise.
  assign deb_level = sync_q && (cnt_q == CNT_MAX);
`else
  assign deb_level = sync_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_prev_q <= 1'b0;
    end else begin
      deb_prev_q <= deb_level;
    end
  end

  assign press = deb_level & ~deb_prev_q;

endmodule

// File: rtl/car_call_panel.sv
// In-car floor-select panel: latches debounced presses as pending calls and
// offers them one at a time over valid/ready. Optional debounce: CAR_PANEL_DEBOUNCE_EN.
module car_call_panel
  import car_panel_pkg::*;
#(
  parameter  int NUM_FLOORS      = 7,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int FLOOR_W         = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] buttons,
  input  logic                  arrived_valid,
  input  logic [FLOOR_W-1:0]    arrived_floor,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    req_floor,
  input  logic                  req_ready,
  output logic [NUM_FLOORS-1:0] pending
);

  logic [NUM_FLOORS-1:0] press_vec;
  logic [NUM_FLOORS-1:0] arr_hit;
  logic [NUM_FLOORS-1:0] take;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] unsent_q, unsent_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic [FLOOR_W-1:0]    lowest_idx;
  logic                  load;
  state_e                state_q, state_d;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .button(buttons[g]),
      .press (press_vec[g])
    );
  end

  // Out-of-range floor codes match no index and are therefore ignored.
  always_comb begin
    arr_hit = '0;
    if (arrived_valid) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        if (arrived_floor == FLOOR_W'(i)) begin
          arr_hit[i] = 1'b1;
        end
      end
    end else begin
      arr_hit = '0;
    end
  end

  assign lowest_idx = FLOOR_W'(lowest_set(MAX_FLOORS'(unsent_q)));

  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|unsent_q) begin
          load    = 1'b1;
          state_d = OFFER;
        end else begin
          state_d = IDLE;
        end
      end
      OFFER: begin
        if (req_ready) begin
          if (|unsent_q) begin
            load    = 1'b1;
            state_d = OFFER;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = OFFER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      req_floor_d = lowest_idx;
    end else begin
      req_floor_d = req_floor_q;
    end
  end

  // Isolate the lowest unsent bit; an arrival never retracts the offer already loaded.
  assign take      = load ? (unsent_q & (~unsent_q + NUM_FLOORS'(1))) : '0;
  assign pending_d = (pending_q | press_vec) & ~arr_hit;
  assign unsent_d  = ((unsent_q & ~take) | (press_vec & ~pending_q)) & ~arr_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_floor_q <= '0;
      pending_q   <= '0;
      unsent_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      pending_q   <= pending_d;
      unsent_q    <= unsent_d;
    end
  end

  assign req_valid = (state_q == OFFER);
  assign req_floor = req_floor_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_car_call_panel.sv
// Directed bench for car_call_panel with a run-length/queue reference model
// compared every cycle; works with or without CAR_PANEL_DEBOUNCE_EN.
module tb_car_call_panel;

  localparam int NF  = 7;
  localparam int DEB = 4;
  localparam int FW  = 3;
`ifdef CAR_PANEL_DEBOUNCE_EN
  localparam int RUN_NEED = DEB + 1;
`else
  localparam int RUN_NEED = 1;
`endif
  localparam int PLAT = RUN_NEED + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] buttons = '0;
  logic          arrived_valid = 1'b0;
  logic [FW-1:0] arrived_floor = '0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [NF-1:0] pending;

  always #5 clk = ~clk;

  car_call_panel #(
    .NUM_FLOORS(NF),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons(buttons),
    .arrived_valid(arrived_valid),
    .arrived_floor(arrived_floor),
    .req_valid(req_valid),
    .req_floor(req_floor),
    .req_ready(req_ready),
    .pending(pending)
  );

  int n_checks = 0;
  int n_pass = 0;
  int got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a press is accepted when a button has been sampled high
  // RUN_NEED times in a row; calls are a bit set, the offer is lowest-first.
  int            run_m[NF];
  bit            deb_m[NF];
  logic [NF-1:0] press_m, pend_m, unsent_m;
  bit            off_v;
  int            off_f;

  function automatic int lowest(input logic [NF-1:0] v);
    for (int i = 0; i < NF; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NF; i++) begin
      run_m[i] = 0;
      deb_m[i] = 1'b0;
    end
    press_m = '0; pend_m = '0; unsent_m = '0; off_v = 1'b0; off_f = 0;
  endtask

  task automatic model_step();
    logic [NF-1:0] arr, fresh;
    bit d;
    arr = '0;
    if (arrived_valid && int'(arrived_floor) < NF) arr[arrived_floor] = 1'b1;
    if (!off_v || req_ready) begin
      if (unsent_m != 0) begin
        off_f = lowest(unsent_m);
        unsent_m[off_f] = 1'b0;
        off_v = 1'b1;
      end else begin
        off_v = 1'b0;
      end
    end
    fresh    = press_m & ~pend_m;
    pend_m   = (pend_m | press_m) & ~arr;
    unsent_m = (unsent_m | fresh) & ~arr;
    for (int i = 0; i < NF; i++) begin
      d = (run_m[i] >= RUN_NEED);
      press_m[i] = d && !deb_m[i];
      deb_m[i] = d;
      run_m[i] = buttons[i] ? ((run_m[i] < 1000) ? run_m[i] + 1 : run_m[i]) : 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_clear();
      else model_step();
      @(negedge clk);
      if (reset) model_clear();
      n_checks++;
      if (req_valid === off_v && req_floor === FW'(off_f) && pending === pend_m) n_pass++;
      else $display("FAIL model_cycle t=%0t: valid=%0b floor=%0d pending=%h, expected valid=%0b floor=%0d pending=%h",
                    $time, req_valid, req_floor, pending, off_v, off_f, pend_m);
      if (req_valid && req_ready && !reset) got.push_back(int'(req_floor));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_hold(input logic [NF-1:0] mask, input int n);
    buttons = mask;
    ticks(n);
    buttons = '0;
  endtask

  task automatic arrive(input int f);
    arrived_valid = 1'b1;
    arrived_floor = FW'(f);
    tick();
    arrived_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c;
    c = 0;
    while (!req_valid && c < budget) begin
      tick();
      c++;
    end
    check(name, req_valid, 1);
  endtask

  initial begin
    ticks(3);
    check("reset_valid", req_valid, 0);
    check("reset_floor", req_floor, 0);
    check("reset_pending", pending, 0);
    reset = 1'b0;
    tick();

    // single press
    req_ready = 1'b1;
    got.delete();
    buttons = 7'h04;
    ticks(PLAT);
    check("t1_pending_early", pending, 0);
    tick();
    check("t1_pending_set", pending, 7'h04);
    ticks(4);
    buttons = '0;
    ticks(4);
    check("t1_transfers", got.size(), 1);
    if (got.size() > 0) check("t1_floor", got[0], 2);
    check("t1_pending_held", pending, 7'h04);
    arrive(2);
    check("t1_pending_cleared", pending, 0);

    // short glitch on floor 3
    got.delete();
    press_hold(7'h08, 3);
    ticks(12);
`ifdef CAR_PANEL_DEBOUNCE_EN
    check("t2_no_transfer", got.size(), 0);
    check("t2_no_pending", pending, 0);
`else
    check("t2_transfers", got.size(), 1);
    if (got.size() > 0) check("t2_floor", got[0], 3);
    arrive(3);
    check("t2_pending_cleared", pending, 0);
`endif

    // simultaneous presses under backpressure
    req_ready = 1'b0;
    got.delete();
    press_hold(7'h29, PLAT + 2);
    wait_valid("t3_valid", 10);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", req_valid, 1);
      check("t3_hold_floor", req_floor, 0);
      tick();
    end
    req_ready = 1'b1;
    tick();
    check("t3_second_floor", req_floor, 3);
    check("t3_second_valid", req_valid, 1);
    tick();
    check("t3_third_floor", req_floor, 5);
    tick();
    check("t3_idle", req_valid, 0);
    check("t3_count", got.size(), 3);
    if (got.size() == 3) begin
      check("t3_order0", got[0], 0);
      check("t3_order1", got[1], 3);
      check("t3_order2", got[2], 5);
    end
    check("t3_pending", pending, 7'h29);
    arrive(0);
    arrive(3);
    arrive(5);
    check("t3_pending_cleared", pending, 0);

    // repeat press and re-request after arrival
    got.delete();
    press_hold(7'h40, PLAT + 2);
    ticks(4);
    check("t4_first", got.size(), 1);
    press_hold(7'h40, PLAT + 2);
    ticks(6);
    check("t4_no_repeat", got.size(), 1);
    check("t4_pending", pending, 7'h40);
    arrive(6);
    check("t4_cleared", pending, 0);
    press_hold(7'h40, PLAT + 2);
    ticks(4);
    check("t4_again", got.size(), 2);
    if (got.size() == 2) check("t4_again_floor", got[1], 6);
    arrive(6);

    // press and arrival on floor 1 at the same edge
    got.delete();
    buttons = 7'h02;
    ticks(PLAT);
    arrived_valid = 1'b1;
    arrived_floor = 3'd1;
    tick();
    arrived_valid = 1'b0;
    check("t5_collision", pending, 0);
    ticks(4);
    check("t5_still_clear", pending, 0);
    check("t5_no_request", got.size(), 0);
    buttons = '0;
    ticks(4);

    // out-of-range arrival
    press_hold(7'h10, PLAT + 2);
    ticks(4);
    check("t5_pending4", pending, 7'h10);
    arrive(7);
    check("t5_range_ignored", pending, 7'h10);
    arrive(4);
    check("t5_range_cleared", pending, 0);

    // reset while offering
    req_ready = 1'b0;
    got.delete();
    press_hold(7'h12, PLAT + 2);
    wait_valid("t6_valid", 10);
    check("t6_pending", pending, 7'h12);
    check("t6_floor", req_floor, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", req_valid, 0);
    check("t6_rst_floor", req_floor, 0);
    check("t6_rst_pending", pending, 0);
    tick();
    reset = 1'b0;
    req_ready = 1'b1;
    got.delete();
    ticks(12);
    check("t6_no_request", got.size(), 0);
    check("t6_idle", req_valid, 0);
    check("t6_no_pending", pending, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
